// File: rtl/maq_hm.sv
// maq_hm: minutes/hours stage of the clock.
//
// Keeps HH:MM in BCD, 00:00..23:59. It advances on the rising edge of the minute carry
// from the seconds stage. Two buttons drive a time-set machine: RUN -> SET_H -> SET_M -> RUN.
// Blink enables for the display are derived from a phase counter that runs only while setting.
// A one-cycle day-carry pulse follows the 23:59 -> 00:00 run rollover.
//
// Ports:
//   clk                system clock, rising edge
//   rst                synchronous active-high reset
//   incrementa_minuto  minute carry (level, high while seconds = 59)
//   btn_modo           debounced mode button, asynchronous to clk
//   btn_inc            debounced increment button, asynchronous to clk
//   bcd_m_lsd/msd      minutes units (0..9) / tens (0..5)
//   bcd_h_lsd/msd      hours units (0..9) / tens (0..2)
//   modo               00 RUN, 01 SET_H, 10 SET_M
//   pisca_h/pisca_m    1 = digit group visible (blanked on the low blink phase while edited)
//   incrementa_dia     one-cycle day carry
module maq_hm #(
  parameter int unsigned PISCA_DIV = 25_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       incrementa_minuto,
  input  logic       btn_modo,
  input  logic       btn_inc,
  output logic [3:0] bcd_m_lsd,
  output logic [2:0] bcd_m_msd,
  output logic [3:0] bcd_h_lsd,
  output logic [1:0] bcd_h_msd,
  output logic [1:0] modo,
  output logic       pisca_h,
  output logic       pisca_m,
  output logic       incrementa_dia
);

  localparam int unsigned CntW = (PISCA_DIV > 1) ? $clog2(PISCA_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(PISCA_DIV - 1);

  typedef enum logic [1:0] {
    StRun  = 2'b00,
    StSetH = 2'b01,
    StSetM = 2'b10
  } mode_e;

  mode_e         mode_q, mode_d;
  logic          c_prev_q;
  logic          modo_s1_q, modo_s2_q, modo_prev_q;
  logic          inc_s1_q, inc_s2_q, inc_prev_q;
  logic [3:0]    m_lsd_q, m_lsd_d;
  logic [2:0]    m_msd_q, m_msd_d;
  logic [3:0]    h_lsd_q, h_lsd_d;
  logic [1:0]    h_msd_q, h_msd_d;
  logic          dia_q, dia_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic          phase_q, phase_d;
  logic          pisca_h_q, pisca_h_d;
  logic          pisca_m_q, pisca_m_d;

  logic          rise_c, rise_modo, rise_inc;
  logic          m_wrap, h_wrap;
  logic [3:0]    m_lsd_inc, h_lsd_inc;
  logic [2:0]    m_msd_inc;
  logic [1:0]    h_msd_inc;

  // The carry is already synchronous to clk, so it acts on the same edge it rises.
  assign rise_c    = incrementa_minuto & ~c_prev_q;
  assign rise_modo = modo_s2_q & ~modo_prev_q;
  assign rise_inc  = inc_s2_q & ~inc_prev_q;

  // Incremented time values. Minutes wrap 59 -> 00 and hours wrap 23 -> 00.
  always_comb begin
    m_wrap    = (m_lsd_q == 4'd9) && (m_msd_q == 3'd5);
    m_lsd_inc = m_lsd_q + 4'd1;
    m_msd_inc = m_msd_q;
    if (m_lsd_q == 4'd9) begin
      m_lsd_inc = 4'd0;
      m_msd_inc = m_wrap ? 3'd0 : m_msd_q + 3'd1;
    end

    h_wrap    = (h_msd_q == 2'd2) && (h_lsd_q == 4'd3);
    h_lsd_inc = h_lsd_q + 4'd1;
    h_msd_inc = h_msd_q;
    if (h_wrap) begin
      h_lsd_inc = 4'd0;
      h_msd_inc = 2'd0;
    end else if (h_lsd_q == 4'd9) begin
      h_lsd_inc = 4'd0;
      h_msd_inc = h_msd_q + 2'd1;
    end
  end

  // Mode machine and time update.
  always_comb begin
    mode_d  = mode_q;
    m_lsd_d = m_lsd_q;
    m_msd_d = m_msd_q;
    h_lsd_d = h_lsd_q;
    h_msd_d = h_msd_q;
    dia_d   = 1'b0;
    case (mode_q)
      StRun: begin
        // A carry coinciding with a mode press is still counted.
        if (rise_c) begin
          m_lsd_d = m_lsd_inc;
          m_msd_d = m_msd_inc;
          if (m_wrap) begin
            h_lsd_d = h_lsd_inc;
            h_msd_d = h_msd_inc;
            dia_d   = h_wrap;
          end
        end
        if (rise_modo) mode_d = StSetH;
      end
      StSetH: begin
        // Mode wins over a simultaneous increment.
        if (rise_modo) begin
          mode_d = StSetM;
        end else if (rise_inc) begin
          h_lsd_d = h_lsd_inc;
          h_msd_d = h_msd_inc;
        end
      end
      StSetM: begin
        if (rise_modo) begin
          mode_d = StRun;
        end else if (rise_inc) begin
          m_lsd_d = m_lsd_inc;
          m_msd_d = m_msd_inc;
        end
      end
      default: mode_d = StRun;
    endcase
  end

  // Blink phase: restarts visible on every mode change, free-runs only while setting.
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (mode_d != mode_q) begin
      cnt_d   = '0;
      phase_d = 1'b1;
    end else if (mode_q != StRun) begin
      if (cnt_q == CntMax) begin
        cnt_d   = '0;
        phase_d = ~phase_q;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end else begin
      cnt_d   = '0;
      phase_d = 1'b1;
    end
    pisca_h_d = (mode_d != StSetH) | phase_d;
    pisca_m_d = (mode_d != StSetM) | phase_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q      <= StRun;
      c_prev_q    <= 1'b0;
      modo_s1_q   <= 1'b0;
      modo_s2_q   <= 1'b0;
      modo_prev_q <= 1'b0;
      inc_s1_q    <= 1'b0;
      inc_s2_q    <= 1'b0;
      inc_prev_q  <= 1'b0;
      m_lsd_q     <= 4'd0;
      m_msd_q     <= 3'd0;
      h_lsd_q     <= 4'd0;
      h_msd_q     <= 2'd0;
      dia_q       <= 1'b0;
      cnt_q       <= '0;
      phase_q     <= 1'b1;
      pisca_h_q   <= 1'b1;
      pisca_m_q   <= 1'b1;
    end else begin
      mode_q      <= mode_d;
      c_prev_q    <= incrementa_minuto;
      modo_s1_q   <= btn_modo;
      modo_s2_q   <= modo_s1_q;
      modo_prev_q <= modo_s2_q;
      inc_s1_q    <= btn_inc;
      inc_s2_q    <= inc_s1_q;
      inc_prev_q  <= inc_s2_q;
      m_lsd_q     <= m_lsd_d;
      m_msd_q     <= m_msd_d;
      h_lsd_q     <= h_lsd_d;
      h_msd_q     <= h_msd_d;
      dia_q       <= dia_d;
      cnt_q       <= cnt_d;
      phase_q     <= phase_d;
      pisca_h_q   <= pisca_h_d;
      pisca_m_q   <= pisca_m_d;
    end
  end

  assign bcd_m_lsd      = m_lsd_q;
  assign bcd_m_msd      = m_msd_q;
  assign bcd_h_lsd      = h_lsd_q;
  assign bcd_h_msd      = h_msd_q;
  assign modo           = mode_q;
  assign pisca_h        = pisca_h_q;
  assign pisca_m        = pisca_m_q;
  assign incrementa_dia = dia_q;

endmodule

// File: tb/tb_maq_hm.sv
// Directed testbench for maq_hm (blink divider shortened to 4 cycles).
module tb_maq_hm;

  logic       clk = 1'b0;
  logic       rst;
  logic       incrementa_minuto;
  logic       btn_modo;
  logic       btn_inc;
  logic [3:0] bcd_m_lsd;
  logic [2:0] bcd_m_msd;
  logic [3:0] bcd_h_lsd;
  logic [1:0] bcd_h_msd;
  logic [1:0] modo;
  logic       pisca_h;
  logic       pisca_m;
  logic       incrementa_dia;

  logic [12:0] t_obs;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          dia_seen = 0;

  maq_hm #(.PISCA_DIV(4)) dut (
    .clk               (clk),
    .rst               (rst),
    .incrementa_minuto (incrementa_minuto),
    .btn_modo          (btn_modo),
    .btn_inc           (btn_inc),
    .bcd_m_lsd         (bcd_m_lsd),
    .bcd_m_msd         (bcd_m_msd),
    .bcd_h_lsd         (bcd_h_lsd),
    .bcd_h_msd         (bcd_h_msd),
    .modo              (modo),
    .pisca_h           (pisca_h),
    .pisca_m           (pisca_m),
    .incrementa_dia    (incrementa_dia)
  );

  always #5 clk = ~clk;

  assign t_obs = {bcd_h_msd, bcd_h_lsd, bcd_m_msd, bcd_m_lsd};

  always @(negedge clk) if (incrementa_dia === 1'b1) dia_seen++;

  // Packs HH:MM into the same layout as t_obs.
  function automatic logic [12:0] to_bcd(input int h, input int m);
    logic [1:0] hm;
    logic [3:0] hl;
    logic [2:0] mm;
    logic [3:0] ml;
    hm = 2'(h / 10);
    hl = 4'(h % 10);
    mm = 3'(m / 10);
    ml = 4'(m % 10);
    return {hm, hl, mm, ml};
  endfunction

  // Stimulus helpers: called at a negedge, return at a negedge with the action settled.
  task automatic press_modo();
    btn_modo = 1'b1;
    @(negedge clk);
    btn_modo = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic press_inc();
    btn_inc = 1'b1;
    @(negedge clk);
    btn_inc = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic set_time(input int h, input int m);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    press_modo();
    repeat (h) press_inc();
    press_modo();
    repeat (m) press_inc();
    press_modo();
  endtask

  task automatic test_reset();
    set_time(12, 34);
    press_modo();
    press_modo();
    n_checks++;
    if (modo !== 2'b10) begin
      n_fail++;
      $display("FAIL reset_pre_modo: got %b expected 10", modo);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (t_obs !== to_bcd(0, 0)) begin
      n_fail++;
      $display("FAIL reset_time: got %h expected %h", t_obs, to_bcd(0, 0));
    end
    n_checks++;
    if (modo !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_modo: got %b expected 00", modo);
    end
    n_checks++;
    if ({pisca_h, pisca_m} !== 2'b11) begin
      n_fail++;
      $display("FAIL reset_pisca: got %b expected 11", {pisca_h, pisca_m});
    end
    n_checks++;
    if (incrementa_dia !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_dia: got %b expected 0", incrementa_dia);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_run_carry();
    set_time(0, 59);
    incrementa_minuto = 1'b1;
    @(negedge clk);
    incrementa_minuto = 1'b0;
    n_checks++;
    if (t_obs !== to_bcd(1, 0)) begin
      n_fail++;
      $display("FAIL carry_00_59: got %h expected %h", t_obs, to_bcd(1, 0));
    end
    @(negedge clk);
    incrementa_minuto = 1'b1;
    repeat (5) @(negedge clk);
    incrementa_minuto = 1'b0;
    @(negedge clk);
    n_checks++;
    if (t_obs !== to_bcd(1, 1)) begin
      n_fail++;
      $display("FAIL carry_held: got %h expected %h", t_obs, to_bcd(1, 1));
    end
  endtask

  task automatic test_day_wrap();
    set_time(23, 59);
    incrementa_minuto = 1'b1;
    @(negedge clk);
    incrementa_minuto = 1'b0;
    n_checks++;
    if (t_obs !== to_bcd(0, 0)) begin
      n_fail++;
      $display("FAIL day_wrap_time: got %h expected %h", t_obs, to_bcd(0, 0));
    end
    n_checks++;
    if (incrementa_dia !== 1'b1) begin
      n_fail++;
      $display("FAIL day_wrap_pulse: got %b expected 1", incrementa_dia);
    end
    @(negedge clk);
    n_checks++;
    if (incrementa_dia !== 1'b0) begin
      n_fail++;
      $display("FAIL day_wrap_pulse_end: got %b expected 0", incrementa_dia);
    end

    set_time(9, 59);
    incrementa_minuto = 1'b1;
    @(negedge clk);
    incrementa_minuto = 1'b0;
    n_checks++;
    if ({t_obs, incrementa_dia} !== {to_bcd(10, 0), 1'b0}) begin
      n_fail++;
      $display("FAIL carry_09_59: got %h/%b expected %h/0", t_obs, incrementa_dia,
               to_bcd(10, 0));
    end

    set_time(19, 59);
    incrementa_minuto = 1'b1;
    @(negedge clk);
    incrementa_minuto = 1'b0;
    n_checks++;
    if ({t_obs, incrementa_dia} !== {to_bcd(20, 0), 1'b0}) begin
      n_fail++;
      $display("FAIL carry_19_59: got %h/%b expected %h/0", t_obs, incrementa_dia,
               to_bcd(20, 0));
    end
  endtask

  task automatic test_set_hours();
    int dia0;
    set_time(22, 0);
    // Held button: acts two edges after the first sampling edge, exactly once.
    btn_modo = 1'b1;
    @(negedge clk);
    n_checks++;
    if (modo !== 2'b00) begin
      n_fail++;
      $display("FAIL modo_edge0: got %b expected 00", modo);
    end
    @(negedge clk);
    n_checks++;
    if (modo !== 2'b00) begin
      n_fail++;
      $display("FAIL modo_edge1: got %b expected 00", modo);
    end
    @(negedge clk);
    n_checks++;
    if (modo !== 2'b01) begin
      n_fail++;
      $display("FAIL modo_edge2: got %b expected 01", modo);
    end
    repeat (4) @(negedge clk);
    btn_modo = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (modo !== 2'b01) begin
      n_fail++;
      $display("FAIL modo_held: got %b expected 01", modo);
    end

    dia0 = dia_seen;
    for (int i = 0; i < 24; i++) begin
      press_inc();
      incrementa_minuto = 1'b1;
      @(negedge clk);
      incrementa_minuto = 1'b0;
      @(negedge clk);
      if (i == 1) begin
        n_checks++;
        if (t_obs !== to_bcd(0, 0)) begin
          n_fail++;
          $display("FAIL set_h_wrap: got %h expected %h", t_obs, to_bcd(0, 0));
        end
      end
    end
    n_checks++;
    if (t_obs !== to_bcd(22, 0)) begin
      n_fail++;
      $display("FAIL set_h_24: got %h expected %h", t_obs, to_bcd(22, 0));
    end
    n_checks++;
    if (dia_seen !== dia0) begin
      n_fail++;
      $display("FAIL set_h_dia: got %0d pulses expected 0", dia_seen - dia0);
    end
  endtask

  task automatic test_set_minutes();
    logic exp_m;
    // Continues in SET_H at 22:00.
    btn_modo = 1'b1;
    @(negedge clk);
    btn_modo = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({modo, pisca_h, pisca_m} !== 4'b1011) begin
      n_fail++;
      $display("FAIL set_m_enter: got %b expected 1011", {modo, pisca_h, pisca_m});
    end
    for (int j = 1; j <= 8; j++) begin
      @(negedge clk);
      exp_m = (j >= 4 && j < 8) ? 1'b0 : 1'b1;
      n_checks++;
      if ({pisca_h, pisca_m} !== {1'b1, exp_m}) begin
        n_fail++;
        $display("FAIL blink_%0d: got %b expected %b", j, {pisca_h, pisca_m}, {1'b1, exp_m});
      end
    end
    repeat (59) press_inc();
    n_checks++;
    if (t_obs !== to_bcd(22, 59)) begin
      n_fail++;
      $display("FAIL set_m_59: got %h expected %h", t_obs, to_bcd(22, 59));
    end
    press_inc();
    n_checks++;
    if (t_obs !== to_bcd(22, 0)) begin
      n_fail++;
      $display("FAIL set_m_wrap: got %h expected %h", t_obs, to_bcd(22, 0));
    end
    press_modo();
    n_checks++;
    if ({modo, pisca_h, pisca_m} !== 4'b0011) begin
      n_fail++;
      $display("FAIL set_m_exit: got %b expected 0011", {modo, pisca_h, pisca_m});
    end
  endtask

  task automatic test_collisions();
    set_time(5, 7);
    press_modo();
    btn_modo = 1'b1;
    btn_inc  = 1'b1;
    @(negedge clk);
    btn_modo = 1'b0;
    btn_inc  = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({modo, t_obs} !== {2'b10, to_bcd(5, 7)}) begin
      n_fail++;
      $display("FAIL modo_inc_same: got %b/%h expected 10/%h", modo, t_obs, to_bcd(5, 7));
    end

    set_time(10, 59);
    btn_modo = 1'b1;
    @(negedge clk);
    btn_modo = 1'b0;
    @(negedge clk);
    incrementa_minuto = 1'b1;
    @(negedge clk);
    incrementa_minuto = 1'b0;
    n_checks++;
    if ({modo, t_obs} !== {2'b01, to_bcd(11, 0)}) begin
      n_fail++;
      $display("FAIL carry_modo_same: got %b/%h expected 01/%h", modo, t_obs, to_bcd(11, 0));
    end
  endtask

  initial begin
    rst               = 1'b1;
    incrementa_minuto = 1'b0;
    btn_modo          = 1'b0;
    btn_inc           = 1'b0;
    @(negedge clk);
    test_reset();
    test_run_carry();
    test_day_wrap();
    test_set_hours();
    test_set_minutes();
    test_collisions();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
